// File: rtl/width_conv_fifo.sv
// width_conv_fifo: single-clock FIFO whose write and read ports have different
// widths. The narrow side walks a sub-word index across each wide memory word,
// so one instance can split wide cache words into narrow frame bytes or pack
// narrow words into wide ones. Occupancy is tracked in units of the narrower
// width, and every flag and water level comes from that unit count.
//
// Optional build macro WIDTH_CONV_FIFO_ERR_FLAG_EN adds the sticky outputs
// wr_overflow and rd_underflow.
module width_conv_fifo #(
  parameter int WR_DATA_WIDTH    = 16,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int WR_DEPTH_WIDTH   = 9,
  parameter int ALMOST_FULL_NUM  = 120,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int LSB_FIRST        = 0,
  localparam int RD_DEPTH_WIDTH  = (RD_DATA_WIDTH > WR_DATA_WIDTH)
                                   ? WR_DEPTH_WIDTH - $clog2(RD_DATA_WIDTH / WR_DATA_WIDTH)
                                   : WR_DEPTH_WIDTH + $clog2(WR_DATA_WIDTH / RD_DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic                      almost_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic                      almost_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level
`ifdef WIDTH_CONV_FIFO_ERR_FLAG_EN
  ,
  output logic                      wr_overflow,
  output logic                      rd_underflow
`endif
);

  // Geometry: the memory is as wide as the wider port; the narrow side owns
  // the sub-word index that selects a slice of one memory word.
  localparam bit IS_UP     = (RD_DATA_WIDTH > WR_DATA_WIDTH);
  localparam int MIN_W     = IS_UP ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int MAX_W     = IS_UP ? RD_DATA_WIDTH : WR_DATA_WIDTH;
  localparam int RATIO     = MAX_W / MIN_W;
  localparam int RATIO_LOG = $clog2(RATIO);
  localparam int SUB_W     = (RATIO_LOG > 0) ? RATIO_LOG : 1;
  localparam int WR_UNITS  = WR_DATA_WIDTH / MIN_W;
  localparam int RD_UNITS  = RD_DATA_WIDTH / MIN_W;
  localparam int WR_SHIFT  = IS_UP ? 0 : RATIO_LOG;
  localparam int RD_SHIFT  = IS_UP ? RATIO_LOG : 0;
  localparam int MEM_AW    = IS_UP ? WR_DEPTH_WIDTH - RATIO_LOG : WR_DEPTH_WIDTH;
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int U_MAX     = (1 << WR_DEPTH_WIDTH) * WR_UNITS;
  localparam int U_W       = $clog2(U_MAX) + 1;

  logic [MAX_W-1:0]          mem_q [MEM_DEPTH];

  // Word pointers carry a wrap bit above the memory index; the index uses
  // the low bits, and full/empty come from the unit count instead.
  logic [MEM_AW:0]           wr_ptr_q, wr_ptr_d;
  logic [MEM_AW:0]           rd_ptr_q, rd_ptr_d;
  logic [MEM_AW-1:0]         wr_addr, rd_addr;
  logic [SUB_W-1:0]          sub_q, sub_d;
  logic [SUB_W-1:0]          slice;
  logic                      sub_last;
  logic [U_W-1:0]            u_q, u_d;
  logic [RD_DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [RD_DATA_WIDTH-1:0]  rd_word;
  logic                      wr_full_q, wr_full_d;
  logic                      almost_full_q, almost_full_d;
  logic [WR_DEPTH_WIDTH:0]   wr_level_q, wr_level_d;
  logic                      rd_empty_q, rd_empty_d;
  logic                      almost_empty_q, almost_empty_d;
  logic [RD_DEPTH_WIDTH:0]   rd_level_q, rd_level_d;
  logic                      wr_acc, rd_acc;
  logic                      wrap_unused;

  assign wr_acc   = wr_en & ~wr_full_q;
  assign rd_acc   = rd_en & ~rd_empty_q;
  assign sub_last = (sub_q == SUB_W'(RATIO - 1));
  assign wr_addr  = wr_ptr_q[MEM_AW-1:0];
  assign rd_addr  = rd_ptr_q[MEM_AW-1:0];

  // The wrap bits only matter for observing pointer laps; fold them into a
  // sink so the index slices above stay the sole consumers of the pointers.
  assign wrap_unused = wr_ptr_q[MEM_AW] ^ rd_ptr_q[MEM_AW];

  // Map the time-ordered sub-word index onto a bit slice of the memory word.
  assign slice = (LSB_FIRST != 0) ? sub_q : (SUB_W'(RATIO - 1) - sub_q);

  // Memory write and narrow/wide read-word selection for the active direction.
  if (IS_UP) begin : g_up
    // Pack: each narrow write lands in one slice of the current wide word.
    always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_addr][int'(slice) * MIN_W +: MIN_W] <= wr_data;
    end

    // A read returns the whole completed wide word.
    always_comb begin
      rd_word = mem_q[rd_addr];
    end
  end else begin : g_dn
    // Split: each wide write fills one memory word.
    always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_addr] <= wr_data;
    end

    // A read returns the slice chosen by the sub-word index.
    always_comb begin
      rd_word = mem_q[rd_addr][int'(slice) * MIN_W +: MIN_W];
    end
  end

  // Next-state for pointers, sub-word index, unit count, read data and flags.
  always_comb begin
    u_d       = u_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sub_d     = sub_q;
    rd_data_d = rd_data_q;

    if (wr_acc) u_d = u_d + U_W'(WR_UNITS);
    if (rd_acc) u_d = u_d - U_W'(RD_UNITS);

    if (IS_UP) begin
      if (wr_acc) begin
        if (sub_last) begin
          sub_d    = '0;
          wr_ptr_d = wr_ptr_q + (MEM_AW + 1)'(1);
        end else begin
          sub_d    = sub_q + SUB_W'(1);
        end
      end
      if (rd_acc) rd_ptr_d = rd_ptr_q + (MEM_AW + 1)'(1);
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + (MEM_AW + 1)'(1);
      if (rd_acc) begin
        if (sub_last) begin
          sub_d    = '0;
          rd_ptr_d = rd_ptr_q + (MEM_AW + 1)'(1);
        end else begin
          sub_d    = sub_q + SUB_W'(1);
        end
      end
    end

    if (rd_acc) rd_data_d = rd_word;

    wr_level_d     = (WR_DEPTH_WIDTH + 1)'(u_d >> WR_SHIFT);
    rd_level_d     = (RD_DEPTH_WIDTH + 1)'(u_d >> RD_SHIFT);
    wr_full_d      = (u_d > U_W'(U_MAX - WR_UNITS));
    rd_empty_d     = (u_d < U_W'(RD_UNITS));
    almost_full_d  = (32'(wr_level_d) >= 32'(ALMOST_FULL_NUM));
    almost_empty_d = (32'(rd_level_d) <= 32'(ALMOST_EMPTY_NUM));
  end

  // State register: everything except the memory array is cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      sub_q          <= '0;
      u_q            <= '0;
      rd_data_q      <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= (ALMOST_FULL_NUM <= 0);
      wr_level_q     <= '0;
      rd_empty_q     <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_level_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      sub_q          <= sub_d;
      u_q            <= u_d;
      rd_data_q      <= rd_data_d;
      wr_full_q      <= wr_full_d;
      almost_full_q  <= almost_full_d;
      wr_level_q     <= wr_level_d;
      rd_empty_q     <= rd_empty_d;
      almost_empty_q <= almost_empty_d;
      rd_level_q     <= rd_level_d;
    end
  end

`ifdef WIDTH_CONV_FIFO_ERR_FLAG_EN
  logic wr_overflow_q, wr_overflow_d;
  logic rd_underflow_q, rd_underflow_d;

  // Sticky error flags: latch any dropped write or ignored read until reset.
  always_comb begin
    wr_overflow_d  = wr_overflow_q | (wr_en & wr_full_q);
    rd_underflow_d = rd_underflow_q | (rd_en & rd_empty_q);
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  assign wr_overflow  = wr_overflow_q;
  assign rd_underflow = rd_underflow_q;
`endif

  assign wr_full        = wr_full_q | (wrap_unused & 1'b0);
  assign almost_full    = almost_full_q;
  assign wr_water_level = wr_level_q;
  assign rd_data        = rd_data_q;
  assign rd_empty       = rd_empty_q;
  assign almost_empty   = almost_empty_q;
  assign rd_water_level = rd_level_q;

endmodule

// File: tb/tb_width_conv_fifo.sv
// Directed bench for width_conv_fifo: a 16->8 MSB-first instance with default
// geometry and a small 8->16 LSB-first instance.
module tb_width_conv_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (16 -> 8, MSB first, 512 write words).
  logic        rst_n = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_full, almost_full, rd_empty, almost_empty;
  logic [9:0]  wr_level;
  logic [10:0] rd_level;
  logic [7:0]  rd_data;

  // Up-conversion instance (8 -> 16, LSB first, 16 write words).
  logic        u_rst_n = 1'b0;
  logic [7:0]  u_wr_data = '0;
  logic        u_wr_en = 1'b0;
  logic        u_rd_en = 1'b0;
  logic        u_wr_full, u_almost_full, u_rd_empty, u_almost_empty;
  logic [4:0]  u_wr_level;
  logic [3:0]  u_rd_level;
  logic [15:0] u_rd_data;

`ifdef WIDTH_CONV_FIFO_ERR_FLAG_EN
  logic        ovf, udf, u_ovf, u_udf;
`endif

  width_conv_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .almost_full(almost_full), .wr_water_level(wr_level),
    .rd_data(rd_data), .rd_en(rd_en), .rd_empty(rd_empty),
    .almost_empty(almost_empty), .rd_water_level(rd_level)
`ifdef WIDTH_CONV_FIFO_ERR_FLAG_EN
    , .wr_overflow(ovf), .rd_underflow(udf)
`endif
  );

  width_conv_fifo #(
    .WR_DATA_WIDTH(8), .RD_DATA_WIDTH(16), .WR_DEPTH_WIDTH(4),
    .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(1), .LSB_FIRST(1)
  ) dut_up (
    .clk(clk), .rst_n(u_rst_n),
    .wr_data(u_wr_data), .wr_en(u_wr_en), .wr_full(u_wr_full),
    .almost_full(u_almost_full), .wr_water_level(u_wr_level),
    .rd_data(u_rd_data), .rd_en(u_rd_en), .rd_empty(u_rd_empty),
    .almost_empty(u_almost_empty), .rd_water_level(u_rd_level)
`ifdef WIDTH_CONV_FIFO_ERR_FLAG_EN
    , .wr_overflow(u_ovf), .rd_underflow(u_udf)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_data;
    int          wl;
    int          rl;
    logic        empty;
    logic        full;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input logic [15:0] wd, input logic re);
    wr_en = we; wr_data = wd; rd_en = re;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic ucyc(input logic we, input logic [7:0] wd, input logic re);
    u_wr_en = we; u_wr_data = wd; u_rd_en = re;
    tick();
    u_wr_en = 1'b0; u_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  e;

    vecs[0] = '{1'b1, 16'h1234, 1'b0, 8'h00, 1, 2, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'hABCD, 1'b0, 8'h00, 2, 4, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 8'h12, 1, 3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 8'h34, 1, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h5678, 1'b1, 8'hAB, 1, 3, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 8'hCD, 1, 2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 8'h56, 0, 1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 8'h78, 0, 0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 8'h78, 0, 0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 16'h0000, 1'b0, 8'h78, 0, 0, 1'b1, 1'b0};

    // Reset state of both instances.
    u_rst_n = 1'b0;
    do_reset();
    u_rst_n = 1'b1;
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_empty", 32'(rd_empty), 32'h1);
    chk("rst_ae", 32'(almost_empty), 32'h1);
    chk("rst_full", 32'(wr_full), 32'h0);
    chk("rst_af", 32'(almost_full), 32'h0);
    chk("rst_wl", 32'(wr_level), 32'h0);
    chk("rst_rl", 32'(rd_level), 32'h0);
    chk("u_rst_empty", 32'(u_rd_empty), 32'h1);
    chk("u_rst_wl", 32'(u_wr_level), 32'h0);

    // Table-driven short sequence on the default instance.
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
      chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rd_data));
      chk($sformatf("vec%0d_wl", i), 32'(wr_level), 32'(vecs[i].wl));
      chk($sformatf("vec%0d_rl", i), 32'(rd_level), 32'(vecs[i].rl));
      chk($sformatf("vec%0d_empty", i), 32'(rd_empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d_full", i), 32'(wr_full), 32'(vecs[i].full));
    end

    // Fill to full, drop one write, then drain completely.
    do_reset();
    for (int i = 0; i < 512; i++) begin
      cyc(1'b1, 16'(16'hFFFF - i), 1'b0);
      if (i == 118) chk("fill_af_119", 32'(almost_full), 32'h0);
      if (i == 119) chk("fill_af_120", 32'(almost_full), 32'h1);
      if (i == 510) chk("fill_full_511", 32'(wr_full), 32'h0);
    end
    chk("fill_full_512", 32'(wr_full), 32'h1);
    chk("fill_wl", 32'(wr_level), 32'd512);
    chk("fill_rl", 32'(rd_level), 32'd1024);
    chk("fill_empty", 32'(rd_empty), 32'h0);
    cyc(1'b1, 16'h0000, 1'b0);
    chk("drop_wl", 32'(wr_level), 32'd512);
    chk("drop_rl", 32'(rd_level), 32'd1024);
    chk("drop_full", 32'(wr_full), 32'h1);
`ifdef WIDTH_CONV_FIFO_ERR_FLAG_EN
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("udf_clear", 32'(udf), 32'h0);
`endif
    for (int j = 0; j < 1024; j++) begin
      cyc(1'b0, 16'h0000, 1'b1);
      w = 16'(16'hFFFF - (j / 2));
      e = ((j % 2) == 0) ? w[15:8] : w[7:0];
      chk($sformatf("drain_data_%0d", j), 32'(rd_data), 32'(e));
      chk($sformatf("drain_ae_%0d", j), 32'(almost_empty), 32'((1023 - j) <= 4));
      if (j == 0) chk("drain_full_u1023", 32'(wr_full), 32'h1);
      if (j == 1) chk("drain_full_u1022", 32'(wr_full), 32'h0);
    end
    chk("drain_empty", 32'(rd_empty), 32'h1);
    chk("drain_rl", 32'(rd_level), 32'h0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("underrun_hold", 32'(rd_data), 32'h00);
    chk("underrun_rl", 32'(rd_level), 32'h0);
    chk("underrun_wl", 32'(wr_level), 32'h0);
`ifdef WIDTH_CONV_FIFO_ERR_FLAG_EN
    chk("udf_set", 32'(udf), 32'h1);
    tick();
    chk("ovf_sticky", 32'(ovf), 32'h1);
    chk("udf_sticky", 32'(udf), 32'h1);
`endif

    // Simultaneous read/write across the 512-word pointer wrap.
    do_reset();
    for (int i = 0; i < 505; i++) cyc(1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 1010; i++) cyc(1'b0, 16'h0000, 1'b1);
    chk("adv_empty", 32'(rd_empty), 32'h1);
    q.delete();
    for (int k = 0; k < 10; k++) begin
      w = 16'(16'h2000 + k);
      cyc(1'b1, w, 1'b0);
      q.push_back(w[15:8]);
      q.push_back(w[7:0]);
    end
    chk("pre_hold_wl", 32'(wr_level), 32'd10);
    for (int k = 0; k < 20; k++) begin
      w = 16'(16'h3000 + k);
      cyc(1'b1, w, 1'b1);
      e = q.pop_front();
      q.push_back(w[15:8]);
      q.push_back(w[7:0]);
      chk($sformatf("hold_data_%0d", k), 32'(rd_data), 32'(e));
      chk($sformatf("hold_wl_%0d", k), 32'(wr_level), 32'((21 + k) / 2));
    end
    chk("post_hold_wl", 32'(wr_level), 32'd20);
    chk("post_hold_rl", 32'(rd_level), 32'd40);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 16'h0000, 1'b1);
      e = q.pop_front();
      chk($sformatf("wrap_data_%0d", k), 32'(rd_data), 32'(e));
    end
    chk("wrap_empty", 32'(rd_empty), 32'h1);

    // Reset mid-stream with the sub-word index at 1.
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("mid_first", 32'(rd_data), 32'h01);
    chk("mid_rl", 32'(rd_level), 32'd599);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_wl", 32'(wr_level), 32'h0);
    chk("mid_rst_rl", 32'(rd_level), 32'h0);
    chk("mid_rst_empty", 32'(rd_empty), 32'h1);
    chk("mid_rst_ae", 32'(almost_empty), 32'h1);
    chk("mid_rst_rd_data", 32'(rd_data), 32'h0);
    cyc(1'b1, 16'hABCD, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("mid_new_hi", 32'(rd_data), 32'hAB);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("mid_new_lo", 32'(rd_data), 32'hCD);
    chk("mid_new_empty", 32'(rd_empty), 32'h1);

    // Up-conversion, LSB first: partial groups stay unreadable.
    ucyc(1'b1, 8'h12, 1'b0);
    chk("up_w1_rl", 32'(u_rd_level), 32'h0);
    chk("up_w1_empty", 32'(u_rd_empty), 32'h1);
    ucyc(1'b1, 8'h34, 1'b0);
    chk("up_w2_rl", 32'(u_rd_level), 32'h1);
    chk("up_w2_empty", 32'(u_rd_empty), 32'h0);
    ucyc(1'b1, 8'h56, 1'b0);
    chk("up_w3_wl", 32'(u_wr_level), 32'd3);
    chk("up_w3_rl", 32'(u_rd_level), 32'h1);
    ucyc(1'b0, 8'h00, 1'b1);
    chk("up_r1_data", 32'(u_rd_data), 32'h3412);
    chk("up_r1_empty", 32'(u_rd_empty), 32'h1);
    chk("up_r1_rl", 32'(u_rd_level), 32'h0);
    chk("up_r1_wl", 32'(u_wr_level), 32'h1);
    ucyc(1'b0, 8'h00, 1'b1);
    chk("up_partial_hold", 32'(u_rd_data), 32'h3412);
    ucyc(1'b1, 8'h78, 1'b0);
    chk("up_w4_empty", 32'(u_rd_empty), 32'h0);
    ucyc(1'b0, 8'h00, 1'b1);
    chk("up_r2_data", 32'(u_rd_data), 32'h7856);
    for (int i = 0; i < 16; i++) begin
      ucyc(1'b1, 8'(8'hA0 + i), 1'b0);
      if (i == 10) chk("up_af_11", 32'(u_almost_full), 32'h0);
      if (i == 11) chk("up_af_12", 32'(u_almost_full), 32'h1);
      if (i == 14) chk("up_full_15", 32'(u_wr_full), 32'h0);
    end
    chk("up_full_16", 32'(u_wr_full), 32'h1);
    chk("up_full_wl", 32'(u_wr_level), 32'd16);
    chk("up_full_rl", 32'(u_rd_level), 32'd8);
    for (int k = 0; k < 8; k++) begin
      ucyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("up_drain_%0d", k), 32'(u_rd_data),
          32'({8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)}));
      chk($sformatf("up_drain_ae_%0d", k), 32'(u_almost_empty), 32'((7 - k) <= 1));
    end
    chk("up_drain_empty", 32'(u_rd_empty), 32'h1);
    chk("up_drain_full", 32'(u_wr_full), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
